// File: rtl/crc32_rx_checker.sv
// crc32_rx_checker: checks the CRC-32 FCS of word-streamed frames and reports per-frame status.
// Define CRC32_RX_CHECKER_ERRCNT_EN to add the saturating bad-frame counter port err_cnt_o.
module crc32_rx_checker (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_data_i,
  input  logic        s_last_i,
  output logic        stat_valid_o,
  input  logic        stat_ready_i,
  output logic        stat_ok_o,
  output logic        stat_runt_o,
  output logic [15:0] stat_len_o,
  output logic [31:0] stat_crc_o
`ifdef CRC32_RX_CHECKER_ERRCNT_EN
  ,
  output logic [15:0] err_cnt_o
`endif
);
  localparam logic [31:0] POLY = 32'hEDB88320;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
  state_t state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_nx, stat_crc_q, stat_crc_d;
  logic [15:0] len_q, len_d, len_nx, stat_len_q, stat_len_d;
  logic ok_q, ok_d, runt_q, runt_d, acc, hs;
  function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c ^ d;
    for (int i = 0; i < 32; i++) r = r[0] ? (r >> 1) ^ POLY : r >> 1;
    return r;
  endfunction
  assign s_ready_o = state_q != REPORT;
  assign stat_valid_o = state_q == REPORT;
  assign stat_ok_o = ok_q;
  assign stat_runt_o = runt_q;
  assign stat_len_o = stat_len_q;
  assign stat_crc_o = stat_crc_q;
  assign acc = s_valid_i && s_ready_o;
  assign hs = stat_valid_o && stat_ready_i;
  assign crc_nx = crc_word(crc_q, s_data_i);
  assign len_nx = &len_q ? len_q : len_q + 16'd1;
  // The running CRC/length re-arm as soon as the last word is captured into the
  // status registers, so the next frame starts clean right after the handshake.
  always_comb begin
    state_d = state_q;
    crc_d = crc_q;
    len_d = len_q;
    ok_d = ok_q;
    runt_d = runt_q;
    stat_len_d = stat_len_q;
    stat_crc_d = stat_crc_q;
    if (acc) begin
      state_d = s_last_i ? REPORT : ACCUM;
      crc_d = s_last_i ? INIT : crc_nx;
      len_d = s_last_i ? 16'd0 : len_nx;
      if (s_last_i) begin
        ok_d = (crc_nx == RESIDUE) && (len_nx >= 16'd2);
        runt_d = len_nx < 16'd2;
        stat_len_d = len_nx;
        stat_crc_d = crc_nx;
      end
    end
    if (hs) state_d = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      crc_q <= INIT;
      len_q <= '0;
      ok_q <= 1'b0;
      runt_q <= 1'b0;
      stat_len_q <= '0;
      stat_crc_q <= '0;
    end else begin
      state_q <= state_d;
      crc_q <= crc_d;
      len_q <= len_d;
      ok_q <= ok_d;
      runt_q <= runt_d;
      stat_len_q <= stat_len_d;
      stat_crc_q <= stat_crc_d;
    end
  end
`ifdef CRC32_RX_CHECKER_ERRCNT_EN
  logic [15:0] err_q, err_d;
  assign err_cnt_o = err_q;
  assign err_d = (hs && !ok_q && !(&err_q)) ? err_q + 16'd1 : err_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= '0;
    else err_q <= err_d;
  end
`endif
endmodule

// File: doc/crc32_rx_checker.md
CRC32_RX_CHECKER -- requirements
Module: crc32_rx_checker

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-002 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port s_valid_i  input  1  input word valid.
REQ-004 SHALL have port s_ready_o  output  1  checker accepts a word this cycle.
REQ-005 SHALL have port s_data_i  input  32  frame word, little-endian: bits [7:0] = first byte, bit 0 = first bit on the wire.
REQ-006 SHALL have port s_last_i  input  1  marks the final word of the frame; that word is the 32-bit FCS.
REQ-007 SHALL have port stat_valid_o  output  1  frame status available.
REQ-008 SHALL have port stat_ready_i  input  1  consumer accepts the status.
REQ-009 SHALL have port stat_ok_o  output  1  FCS correct and frame not runt.
REQ-010 SHALL have port stat_runt_o  output  1  frame shorter than 2 words.
REQ-011 SHALL have port stat_len_o  output  16  words in the frame, including the FCS; saturates at 0xFFFF.
REQ-012 SHALL have port stat_crc_o  output  32  final CRC register value, before any inversion.

Function
REQ-013 SHALL compute CRC-32 with reflected polynomial 0xEDB88320 and right shift, consuming one 32-bit word per accepted beat (s_valid_i && s_ready_o).
REQ-014 SHALL initialise the CRC register to 0xFFFFFFFF at frame start and after each status handshake.
REQ-015 SHALL update the register on every accepted word, including the FCS word.
REQ-016 SHALL implement states IDLE, ACCUM and REPORT:
- IDLE -> ACCUM on an accepted non-last word.
- IDLE -> REPORT on an accepted last word (runt frame).
- ACCUM -> REPORT on an accepted last word.
- REPORT -> IDLE on stat_valid_o && stat_ready_i.
REQ-017 SHALL drive s_ready_o = 1 in IDLE and ACCUM, and 0 in REPORT.
REQ-018 SHALL assert stat_valid_o in the cycle after the last word is accepted (latency 1), and hold it and all stat_* outputs stable until stat_ready_i.
REQ-019 SHALL set stat_ok_o = 1 only when the final register equals residue 0xDEBB20E3 and stat_len_o >= 2.
REQ-020 SHALL, for a 1-word frame, set stat_runt_o = 1 and stat_ok_o = 0, regardless of the CRC.
REQ-021 SHALL increment the length counter on each accepted word and hold it at 0xFFFF once reached; the CRC keeps updating while the counter is saturated.
REQ-022 SHALL ignore s_data_i and s_last_i whenever s_valid_i = 0.
REQ-023 SHALL impose no idle gap between frames: the first word of the next frame is accepted in the cycle after the status handshake.

Reset
REQ-024 SHALL, while rst_i = 1 at a clock edge, enter IDLE and set:
- CRC register = 0xFFFFFFFF, length counter = 0;
- stat_valid_o = 0, stat_ok_o = 0, stat_runt_o = 0, stat_len_o = 0, stat_crc_o = 0;
- s_ready_o = 1 from the first cycle after reset release.
REQ-025 SHALL discard a partially received frame or a pending status when reset is asserted; no status is ever produced for it.

Configuration
REQ-026 SHALL compile a 16-bit output port err_cnt_o when macro CRC32_RX_CHECKER_ERRCNT_EN is defined:
- increments by 1 at each status handshake with stat_ok_o = 0;
- saturates at 0xFFFF;
- reset value 0.
REQ-027 SHALL, when CRC32_RX_CHECKER_ERRCNT_EN is undefined, have no err_cnt_o port and no counter logic; all other behaviour is identical.

Verification
REQ-028 Good frame: words 0x00000000, then 0x2144DF1C with last -> one cycle later stat_valid_o=1, stat_ok_o=1, stat_len_o=2, stat_crc_o=0xDEBB20E3.
REQ-029 Corrupt FCS: words 0x00000000, then 0x2144DF1D with last -> stat_ok_o=0, stat_runt_o=0, stat_len_o=2; err_cnt_o=1 after the handshake (macro defined).
REQ-030 Runt: single word 0xDEBB20E3 with last -> stat_runt_o=1, stat_ok_o=0, stat_len_o=1.
REQ-031 Backpressure: hold stat_ready_i=0 for 5 cycles after a good frame -> s_ready_o=0 and stat_* stable throughout; a second good frame presented back-to-back is accepted starting the cycle after the handshake and reports ok.
REQ-032 Reset mid-frame: 3 words accepted, then rst_i=1 for 1 cycle, then the good frame of REQ-028 -> exactly one status, with ok=1 and len=2.
REQ-033 Valid gaps: the REQ-028 frame with s_valid_i=0 cycles and garbage data between words -> same result as REQ-028.
